// File: rtl/dat_fifo_if.sv
// Handshake and status bundle between a DAT data-path client and dat_fifo.
// The client drives the request side through master; the buffer itself uses slave.
interface dat_fifo_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic              clear;
    logic              wr_enb;
    logic [WIDTH-1:0]  din;
    logic              rd_enb;
    logic [WIDTH-1:0]  dout;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, wr_enb, din, rd_enb,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, wr_enb, din, rd_enb,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/dat_fifo.sv
// First-word-fall-through buffer between the host data path and the DAT physical layer.
// All status is decoded from the registered count; dout is a direct read of the head slot.
module dat_fifo #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic      sd_clk,
    input  logic      rst_L,
    dat_fifo_if.slave bus
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);

    // A full buffer still takes a push when the head leaves in the same cycle
    assign w_pop  = bus.rd_enb && !w_empty;
    assign w_push = bus.wr_enb && (!w_full || w_pop);

    always_ff @(posedge sd_clk) begin
        if (w_push && !bus.clear) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Pop on empty is flagged even when a push lands in the same cycle
            if (bus.wr_enb && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_enb && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.dout         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= AF_CNT);
    assign bus.almost_empty = (r_count <= AE_CNT);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_dat_fifo.sv
// Self-checking bench for dat_fifo: directed vector table, queue-model sequences,
// randomized traffic and an asynchronous reset in the middle of a clock interval.
module tb_dat_fifo;
    localparam int DEPTH = 8;

    typedef struct {
        logic        clr;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic        empty;
        logic        full;
        logic        af;
        logic        ae;
        logic [3:0]  count;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic        sd_clk;
    logic        rst_L;
    int          testsRun;
    int          testsFailed;
    logic [31:0] modelQ [$];
    logic        modelOvf;
    logic        modelUnf;
    vec_t        vecs [$];

    dat_fifo_if #(.WIDTH(32), .ADDR_W(3)) bus ();

    dat_fifo #(.WIDTH(32), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .sd_clk (sd_clk),
        .rst_L  (rst_L),
        .bus    (bus)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    function automatic vec_t mkVec(input logic clr, input logic wr, input logic rd,
                                   input logic [31:0] din, input logic [31:0] eDout,
                                   input int eCount, input logic eOvf, input logic eUnf);
        vec_t v;
        v.clr   = clr;
        v.wr    = wr;
        v.rd    = rd;
        v.din   = din;
        v.dout  = eDout;
        v.empty = (eCount == 0);
        v.full  = (eCount == DEPTH);
        v.af    = (eCount >= 6);
        v.ae    = (eCount <= 1);
        v.count = 4'(eCount);
        v.ovf   = eOvf;
        v.unf   = eUnf;
        return v;
    endfunction

    function automatic vec_t modelExpect();
        logic [31:0] head;
        head = (modelQ.size() > 0) ? modelQ[0] : 32'h0;
        return mkVec(1'b0, 1'b0, 1'b0, 32'h0, head, modelQ.size(), modelOvf, modelUnf);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        testsRun++;
        if (act !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        chk({tag, ".dout"},  bus.dout, e.dout);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(e.empty));
        chk({tag, ".full"},  32'(bus.full), 32'(e.full));
        chk({tag, ".af"},    32'(bus.almost_full), 32'(e.af));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(e.ae));
        chk({tag, ".count"}, 32'(bus.count), 32'(e.count));
        chk({tag, ".ovf"},   32'(bus.overflow), 32'(e.ovf));
        chk({tag, ".unf"},   32'(bus.underflow), 32'(e.unf));
    endtask

    task automatic applyStimulus(input logic clr, input logic wr, input logic rd, input logic [31:0] din);
        bus.clear  = clr;
        bus.wr_enb = wr;
        bus.rd_enb = rd;
        bus.din    = din;
        @(posedge sd_clk);
        #1;
    endtask

    // Reference behaviour: a word queue plus two sticky bits
    task automatic modelStep(input logic clr, input logic wr, input logic rd, input logic [31:0] din);
        bit popOk;
        bit pushOk;
        if (clr) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            popOk  = rd && (modelQ.size() > 0);
            pushOk = wr && ((modelQ.size() < DEPTH) || popOk);
            if (rd && modelQ.size() == 0) modelUnf = 1'b1;
            if (wr && !pushOk) modelOvf = 1'b1;
            if (popOk) void'(modelQ.pop_front());
            if (pushOk) modelQ.push_back(din);
        end
    endtask

    task automatic stepModel(input string tag, input logic clr, input logic wr, input logic rd,
                             input logic [31:0] din);
        applyStimulus(clr, wr, rd, din);
        modelStep(clr, wr, rd, din);
        checkOutput(tag, modelExpect());
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        modelOvf    = 1'b0;
        modelUnf    = 1'b0;
        bus.clear   = 1'b0;
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
        bus.din     = 32'h0;
        rst_L       = 1'b0;

        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkVec(0, 1, 0, 32'(32'h11111111 * k), 32'h11111111, k, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 32'hDEADBEEF, 32'h11111111, 8, 1, 0));
        for (int j = 1; j <= 8; j++)
            vecs.push_back(mkVec(0, 0, 1, 32'h0, (j < 8) ? 32'(32'h11111111 * (j + 1)) : 32'h0, 8 - j, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 32'h0, 32'h0, 0, 1, 1));
        vecs.push_back(mkVec(1, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkVec(0, 1, 0, 32'(32'h11111111 * k), 32'h11111111, k, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 32'hCAFE0000, 32'h22222222, 8, 0, 0));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mkVec(0, 0, 1, 32'h0, (i < 7) ? 32'(32'h11111111 * (i + 2)) : 32'hCAFE0000, 8 - i, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 32'h0, 32'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 32'h12345678, 32'h12345678, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 32'h0, 32'h0, 0, 0, 0));

        #12;
        checkOutput("reset", mkVec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        rst_L = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Wrap-around across the pointer rollover
        for (int i = 0; i < 5; i++) stepModel("wrapFill", 0, 1, 0, 32'(32'h100 + i));
        for (int i = 0; i < 5; i++) stepModel("wrapDrain", 0, 0, 1, 32'h0);
        for (int i = 0; i < 6; i++) stepModel("wrapPush", 0, 1, 0, 32'(32'hA0 + i));
        for (int i = 0; i < 6; i++) stepModel("wrapPop", 0, 0, 1, 32'h0);

        // Clear beats a simultaneous write with sticky flags set
        stepModel("clrUnf", 0, 0, 1, 32'h0);
        for (int i = 0; i < 8; i++) stepModel("clrFill", 0, 1, 0, 32'(32'h200 + i));
        stepModel("clrOvf", 0, 1, 0, 32'h0BAD0BAD);
        for (int i = 0; i < 3; i++) stepModel("clrPop", 0, 0, 1, 32'h0);
        stepModel("clrWr", 1, 1, 0, 32'h00000077);
        stepModel("postClr", 0, 1, 0, 32'h00000055);
        stepModel("postClrPop", 0, 0, 1, 32'h0);

        // Randomized traffic, first biased toward filling then toward draining
        for (int i = 0; i < 400; i++) begin
            logic rClr;
            logic rWr;
            logic rRd;
            rClr = ($urandom_range(0, 39) == 0);
            rWr  = ($urandom_range(0, 99) < ((i < 200) ? 70 : 40));
            rRd  = ($urandom_range(0, 99) < ((i < 200) ? 40 : 70));
            stepModel($sformatf("rand%0d", i), rClr, rWr, rRd, $urandom);
        end

        // Asynchronous reset dropped between edges with three words held
        stepModel("arClr", 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) stepModel("arFill", 0, 1, 0, 32'(32'h300 + i));
        bus.wr_enb = 1'b0;
        #3;
        rst_L = 1'b0;
        #1;
        checkOutput("asyncReset", mkVec(0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        modelQ.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        #2;
        rst_L = 1'b1;
        stepModel("arPush", 0, 1, 0, 32'hBEEF0001);
        stepModel("arIdle", 0, 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/dat_fifo.md
# dat_fifo

Synchronous first-word-fall-through (FWFT) data buffer between the host-side data path and the DAT physical layer. Instantiated twice: as the Tx buffer, whose head word is read combinationally and popped by the DAT physical layer's `tx_buf_rd_enb`, and as the Rx buffer, which is filled by its `rx_buf_wr_enb` / `rx_buf_din_out`. Provides occupancy, almost-full/almost-empty levels and sticky error flags for flow control of `write_flag` / `read_flag`.

## Interface
Parameters:
- `WIDTH`, default `FIFO_WIDTH` (32): word width in bits.
- `ADDR_W`, default 3: address width. DEPTH = 2^ADDR_W (8 words). Only power-of-two depths are supported.
- `AF_LEVEL`, default 6: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, default 1: `almost_empty` asserts when count ≤ AE_LEVEL.

Ports:
- `sd_clk`  in  1  single clock; all state updates on its rising edge.
- `rst_L`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; takes effect at the next rising edge.
- `wr_enb`  in  1  push request.
- `din`  in  WIDTH  data to push.
- `rd_enb`  in  1  pop request; the current `dout` is consumed.
- `dout`  out  WIDTH  head word. Combinational from storage while not empty; 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  ADDR_W+1  occupancy, range 0..DEPTH.
- `overflow`  out  1  sticky: a push was attempted while full and was dropped.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wr_ptr` and read pointer `rd_ptr` (each ADDR_W bits), and a `count` register (ADDR_W+1 bits).
- Pointers wrap modulo DEPTH (DEPTH−1 → 0) with natural binary rollover. No pointer-extension bit is used; `full` and `empty` are derived only from `count`.
- A push is accepted when `wr_enb` and (not full, or `rd_enb` is asserted while not empty):
  - `mem[wr_ptr]` ← `din`
  - `wr_ptr` ← `wr_ptr` + 1
- A pop is accepted when `rd_enb` and not empty:
  - `rd_ptr` ← `rd_ptr` + 1
- Count update:
  - +1 for an accepted push only.
  - −1 for an accepted pop only.
  - Unchanged when both are accepted or neither is.
- Boundary cases:
  - Push while full with no accepted pop: the push is dropped; `overflow` ← 1. Storage and pointers are unchanged.
  - Push and pop together while full: both are accepted. The old head leaves, `din` enters, count stays DEPTH, `overflow` is not set.
  - Pop while empty: ignored; `underflow` ← 1.
  - Push and pop together while empty: the push is accepted and the pop is ignored. Count becomes 1 and `underflow` ← 1, because `dout` was invalid in that cycle.
- `clear` has priority over push and pop in the same cycle. It zeroes both pointers, `count`, `overflow` and `underflow`. Memory contents are not cleared.
- Sticky flags clear only on `clear` or reset.
- Reset (`rst_L` low, asynchronous, may occur mid-operation): pointers, count and sticky flags go to 0 immediately. Memory is not reset.
- Reset values of all outputs: `dout`=0, `empty`=1, `full`=0, `almost_full`=0, `almost_empty`=1, `count`=0, `overflow`=0, `underflow`=0.

## Timing
- Push latency: a word pushed at edge N appears on `dout` after edge N when the FIFO was empty. At that same point `empty` falls and `count` increments.
- Pop: `dout` advances to the next word after the edge that samples `rd_enb`.
- `rd_enb` may depend combinationally on `dout` and `empty` in the consumer. There must be no combinational path from `rd_enb` or `wr_enb` to `dout`, `empty`, `full` or `count`.
- All status outputs are decoded from registered state only: `count` and pointers. They update one edge after the causing request.
- Sustained throughput: one push and one pop per cycle at any occupancy between 1 and DEPTH.

## Test plan
- Reset, then 8 pushes of 0x11111111·k (k=1..8) → `full`=1 and `count`=8 after the 8th edge. `almost_full` rises after the 6th edge. A 9th push of 0xDEADBEEF is dropped and `overflow`=1.
- Pop 8 times from the full state → `dout` shows 0x11111111 through 0x88888888 in order. `empty`=1 after the 8th edge. A 9th pop sets `underflow`=1 and `dout`=0.
- Wrap-around: push 5, pop 5, then push 6 of 0xA0..0xA5 and pop 6 → data returns in order across the pointer wrap (index 7→0) with count tracking 6→0.
- Simultaneous push and pop at full, with `din`=0xCAFE0000 → count stays 8 and no overflow. After 7 further pops, `dout`=0xCAFE0000. Simultaneous push and pop while empty → count becomes 1 and `underflow`=1.
- With count=5 and sticky flags set, assert `clear` together with `wr_enb` → next cycle `count`=0, `empty`=1, both flags 0, and the write is discarded.
- Drop `rst_L` asynchronously mid-edge-interval with count=3 → outputs take their reset values before the next `sd_clk` edge. After release, the first push is visible on `dout` one edge later.
